cond_logic: RTL and testbench

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_pkg.sv | 31 +++
 rtl/cond_check.sv | 45 ++++
 rtl/cond_logic.sv | 79 +++++++
 tb/tb_cond_logic.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution slice: flag layout and
// the ARM condition-code encoding.
package cond_pkg;

  localparam int FLAG_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction with the
// given condition field passes against the stored (active-high) NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              condEx
);

  logic n_s;
  logic z_s;
  logic c_s;
  logic v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Condition-code decode against the stored flags
  always_comb begin
    condEx = 1'b0;
    case (cond_e'(cond))
      COND_EQ: condEx = z_s;
      COND_NE: condEx = ~z_s;
      COND_CS: condEx = c_s;
      COND_CC: condEx = ~c_s;
      COND_MI: condEx = n_s;
      COND_PL: condEx = ~n_s;
      COND_VS: condEx = v_s;
      COND_VC: condEx = ~v_s;
      COND_HI: condEx = c_s & ~z_s;
      COND_LS: condEx = ~c_s | z_s;
      COND_GE: condEx = (n_s == v_s);
      COND_LT: condEx = (n_s != v_s);
      COND_GT: condEx = ~z_s & (n_s == v_s);
      COND_LE: condEx = z_s | (n_s != v_s);
      COND_AL: condEx = 1'b1;
      COND_NV: condEx = 1'b0;
      default: condEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Execute-stage conditional logic: holds the NZCV flag register and gates the
// branch / register-write / memory-write controls into the memory stage.
module cond_logic
  import cond_pkg::*;
#(
  parameter int FLAG_W = cond_pkg::FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        cond,
  input  logic [1:0]        flagW,
  input  logic [FLAG_W-1:0] aluFlags,
  input  logic              pcS,
  input  logic              regW,
  input  logic              memW,
  output logic              condEx,
  output logic [FLAG_W-1:0] flags,
  output logic              pcSrc_q,
  output logic              regWrite_q,
  output logic              memWrite_q
);

  logic [FLAG_W-1:0] flags_r;
  logic              pc_src_r;
  logic              reg_write_r;
  logic              mem_write_r;
  logic              cond_ex_s;
  logic              issue_s;
  logic              go_s;

  cond_check u_cond_check (
    .cond   (cond),
    .flags  (flags_r),
    .condEx (cond_ex_s)
  );

  // Controls may pass while stalled; flag writes additionally need !stall.
  assign issue_s = valid_in & cond_ex_s & ~flush;
  assign go_s    = issue_s & ~stall;

  // Flag register and memory-stage control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r     <= {FLAG_W{1'b0}};
      pc_src_r    <= 1'b0;
      reg_write_r <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      if (go_s && flagW[1]) begin
        flags_r[FLAG_N] <= ~aluFlags[FLAG_N];
        flags_r[FLAG_Z] <= ~aluFlags[FLAG_Z];
      end
      if (go_s && flagW[0]) begin
        flags_r[FLAG_C] <= ~aluFlags[FLAG_C];
        flags_r[FLAG_V] <= ~aluFlags[FLAG_V];
      end
      // Flush beats stall so a squashed instruction never reaches memory.
      if (flush) begin
        pc_src_r    <= 1'b0;
        reg_write_r <= 1'b0;
        mem_write_r <= 1'b0;
      end else if (!stall) begin
        pc_src_r    <= pcS  & issue_s;
        reg_write_r <= regW & issue_s;
        mem_write_r <= memW & issue_s;
      end
    end
  end

  assign condEx     = cond_ex_s;
  assign flags      = flags_r;
  assign pcSrc_q    = pc_src_r;
  assign regWrite_q = reg_write_r;
  assign memWrite_q = mem_write_r;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: an abstract flag/condition model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic       stall;
  logic       flush;
  logic [3:0] cond;
  logic [1:0] flagW;
  logic [3:0] aluFlags;
  logic       pcS;
  logic       regW;
  logic       memW;
  logic       condEx;
  logic [3:0] flags;
  logic       pcSrc_q;
  logic       regWrite_q;
  logic       memWrite_q;

  int checks = 0;
  int errors = 0;

  cond_logic #(.FLAG_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .stall      (stall),
    .flush      (flush),
    .cond       (cond),
    .flagW      (flagW),
    .aluFlags   (aluFlags),
    .pcS        (pcS),
    .regW       (regW),
    .memW       (memW),
    .condEx     (condEx),
    .flags      (flags),
    .pcSrc_q    (pcSrc_q),
    .regWrite_q (regWrite_q),
    .memWrite_q (memWrite_q)
  );

  always #5 clk = ~clk;

  // ARM rule: cond[3:1] picks a predicate, cond[0] inverts it (AL/NV included).
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [3:0] m_flags;
  logic [2:0] m_q;
  logic       model_ok = 1'b0;
  logic       m_issue;

  assign m_issue = valid_in & cond_pass(cond, m_flags) & ~flush;

  always @(posedge clk) begin
    if (rst) begin
      m_flags  <= 4'b0000;
      m_q      <= 3'b000;
      model_ok <= 1'b1;
    end else begin
      if (m_issue && !stall && flagW[1]) m_flags[3:2] <= ~aluFlags[3:2];
      if (m_issue && !stall && flagW[0]) m_flags[1:0] <= ~aluFlags[1:0];
      if (flush) m_q <= 3'b000;
      else if (!stall) m_q <= {pcS, regW, memW} & {3{m_issue}};
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmp_condEx", {3'b000, condEx}, {3'b000, cond_pass(cond, m_flags)});
      chk("cmp_flags", flags, m_flags);
      chk("cmp_q", {1'b0, pcSrc_q, regWrite_q, memWrite_q}, {1'b0, m_q});
    end
  end

  task automatic setin(input logic v, input logic st, input logic fl, input logic [3:0] c,
                       input logic [1:0] fw, input logic [3:0] alu,
                       input logic p, input logic r, input logic m);
    valid_in = v; stall = st; flush = fl; cond = c; flagW = fw;
    aluFlags = alu; pcS = p; regW = r; memW = m;
  endtask

  task automatic idle();
    setin(1'b0, 1'b0, 1'b0, 4'hE, 2'b00, 4'hF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] qv();
    return {1'b0, pcSrc_q, regWrite_q, memWrite_q};
  endfunction

  initial begin
    logic [3:0] fv;
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", flags, 4'b0000);
    chk("reset_q", qv(), 4'b0000);

    // NE passes on cleared flags, regWrite appears one cycle later
    setin(1'b1, 1'b0, 1'b0, 4'h1, 2'b00, 4'hF, 1'b0, 1'b1, 1'b0);
    @(negedge clk); chk("ne_condEx", {3'b000, condEx}, 4'b0001); tick();
    idle();
    @(negedge clk); chk("ne_regw", qv(), 4'b0010); chk("ne_flags", flags, 4'b0000); tick();

    // AL sets Z; EQ then passes, NE then fails and gates regWrite
    setin(1'b1, 1'b0, 1'b0, 4'hE, 2'b11, 4'b1011, 1'b0, 1'b0, 1'b0); tick();
    setin(1'b1, 1'b0, 1'b0, 4'h0, 2'b00, 4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("z_flags", flags, 4'b0100); chk("eq_pass", {3'b000, condEx}, 4'b0001); tick();
    setin(1'b1, 1'b0, 1'b0, 4'h1, 2'b00, 4'hF, 1'b0, 1'b1, 1'b0);
    @(negedge clk); chk("ne_fail", {3'b000, condEx}, 4'b0000); tick();
    idle();
    @(negedge clk); chk("ne_fail_regw", qv(), 4'b0000); tick();

    // Failing instruction with flagW=11 leaves flags alone
    setin(1'b1, 1'b0, 1'b0, 4'h1, 2'b11, 4'b0000, 1'b0, 0, 0); tick();
    idle();
    @(negedge clk); chk("fail_noflag", flags, 4'b0100); tick();

    // N set; LT passes and clears flags; LT with flagW=00 keeps them
    setin(1'b1, 1'b0, 1'b0, 4'hE, 2'b11, 4'b0111, 1'b0, 1'b0, 1'b0); tick();
    setin(1'b1, 1'b0, 1'b0, 4'hB, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("n_flags", flags, 4'b1000); chk("lt_pass", {3'b000, condEx}, 4'b0001); tick();
    idle();
    @(negedge clk); chk("lt_flags", flags, 4'b0000); tick();
    setin(1'b1, 1'b0, 1'b0, 4'hE, 2'b11, 4'b0111, 1'b0, 1'b0, 1'b0); tick();
    setin(1'b1, 1'b0, 1'b0, 4'hB, 2'b00, 4'b1111, 1'b0, 1'b0, 1'b0); tick();
    idle();
    @(negedge clk); chk("lt_noflagw", flags, 4'b1000); tick();

    // Stall for three cycles holds flags and controls
    setin(1'b1, 1'b0, 1'b0, 4'hE, 2'b00, 4'hF, 1'b0, 1'b1, 1'b0); tick();
    setin(1'b1, 1'b1, 1'b0, 4'hE, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("stall_flags", flags, 4'b1000); chk("stall_q", qv(), 4'b0010); tick();
    end
    setin(1'b1, 1'b0, 1'b0, 4'hE, 2'b11, 4'b0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk); chk("stall_hold_flags", flags, 4'b1000); chk("stall_hold_q", qv(), 4'b0010); tick();

    // Stall+flush: controls clear, flags hold
    setin(1'b1, 1'b1, 1'b1, 4'hE, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("unstall_flags", flags, 4'b1111); chk("unstall_q", qv(), 4'b0101); tick();
    idle();
    @(negedge clk); chk("stflush_q", qv(), 4'b0000); chk("stflush_flags", flags, 4'b1111); tick();

    // Flush alone squashes a passing instruction
    setin(1'b1, 1'b0, 1'b0, 4'hE, 2'b00, 4'hF, 1'b1, 1'b1, 1'b1); tick();
    setin(1'b1, 1'b0, 1'b1, 4'hE, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1);
    @(negedge clk); chk("pre_flush_q", qv(), 4'b0111); tick();
    idle();
    @(negedge clk); chk("flush_q", qv(), 4'b0000); chk("flush_flags", flags, 4'b1111); tick();

    // Reset mid-operation discards the pending update
    setin(1'b1, 1'b0, 1'b0, 4'hE, 2'b11, 4'b1011, 1'b1, 1'b1, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    setin(1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_flags", flags, 4'b0000); chk("midrst_q", qv(), 4'b0000);
    chk("midrst_eq", {3'b000, condEx}, 4'b0000); tick();
    cond = 4'h1;
    @(negedge clk); chk("midrst_ne", {3'b000, condEx}, 4'b0001); tick();

    // Sweep every condition against every flag state
    for (int f = 0; f < 16; f++) begin
      fv = f[3:0];
      setin(1'b1, 1'b0, 1'b0, 4'hE, 2'b11, ~fv, 1'b0, 1'b0, 1'b0); tick();
      for (int c = 0; c < 16; c++) begin
        setin(1'b0, 1'b0, 1'b0, c[3:0], 2'b00, 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        if (c == 0) chk("sweep_flags", flags, fv);
        if (c == 15) chk("sweep_nv", {3'b000, condEx}, 4'b0000);
        tick();
      end
    end

    idle(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
